// File: rtl/msrv32_dmem_responder.sv
// Data-memory slave for the msrv32 load/store bus. It accepts pipelined AHB-lite transfers and adds programmable wait states.
// Defining MSRV32_DMEM_ERRRESP_EN adds range and mask checking, answered with a two-cycle ERROR response.
module msrv32_dmem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  input  logic        ms_riscv32_mp_req_in,
  input  logic [1:0]  ahb_htrans_in,
  output logic        ahb_ready_out,
  output logic        ahb_resp_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

`ifdef MSRV32_DMEM_ERRRESP_EN
  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [3:0]       mask_reg;
  logic             write_reg;
  logic [3:0]       cnt_reg;
  logic             ready_reg;

  logic [31:0]      offset;
  logic [IDX_W-1:0] idx_next;
  logic             accept;
  logic             final_cycle;
  logic             commit;
  logic [31:0]      rd_word;

  assign offset      = ms_riscv32_mp_dmaddr_in - BASE_ADDR;
  assign idx_next    = IDX_W'(offset >> 2);
  assign accept      = ready_reg && ms_riscv32_mp_req_in &&
                       (ahb_htrans_in == 2'b10 || ahb_htrans_in == 2'b11);
  assign final_cycle = (state_reg == DATA) && (cnt_reg == 4'd0);
  // Reset wins over the closing edge, so an aborted write never lands.
  assign commit      = final_cycle && write_reg && ms_riscv32_mp_rst_in;

`ifdef MSRV32_DMEM_ERRRESP_EN
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
  logic resp_reg;
  logic in_range;
  logic mask_ok;
  logic bad_req;

  assign in_range = (ms_riscv32_mp_dmaddr_in >= BASE_ADDR) && ({1'b0, offset} < SPAN);

  always_comb begin
    mask_ok = 1'b0;
    case (ms_riscv32_mp_dmwr_mask_in)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: mask_ok = 1'b1;
      default:                   mask_ok = 1'b0;
    endcase
  end

  assign bad_req      = !in_range || !mask_ok;
  assign ahb_resp_out = resp_reg;
`else
  assign ahb_resp_out = 1'b0;
`endif

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      mask_reg  <= '0;
      write_reg <= 1'b0;
      cnt_reg   <= '0;
      ready_reg <= 1'b1;
`ifdef MSRV32_DMEM_ERRRESP_EN
      resp_reg  <= 1'b0;
`endif
    end else if (accept) begin
      idx_reg   <= idx_next;
      mask_reg  <= ms_riscv32_mp_dmwr_mask_in;
      write_reg <= |ms_riscv32_mp_dmwr_mask_in;
`ifdef MSRV32_DMEM_ERRRESP_EN
      if (bad_req) begin
        state_reg <= ERR1;
        cnt_reg   <= '0;
        ready_reg <= 1'b0;
        resp_reg  <= 1'b1;
      end else
`endif
      begin
        state_reg <= DATA;
        cnt_reg   <= WS;
        ready_reg <= (WS == 4'd0);
`ifdef MSRV32_DMEM_ERRRESP_EN
        resp_reg  <= 1'b0;
`endif
      end
    end else begin
      case (state_reg)
        DATA: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg   <= cnt_reg - 4'd1;
            ready_reg <= (cnt_reg == 4'd1);
          end else begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
          end
        end
`ifdef MSRV32_DMEM_ERRRESP_EN
        ERR1: begin
          state_reg <= ERR2;
          ready_reg <= 1'b1;
          resp_reg  <= 1'b1;
        end
        ERR2: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          resp_reg  <= 1'b0;
        end
`endif
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // One byte-wide RAM per lane keeps masked writes free of read-modify-write.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (commit && mask_reg[gi]) begin
          mem[idx_reg] <= ms_riscv32_mp_dmdata_in[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = mem[idx_reg];
    end
  endgenerate

  assign ahb_ready_out            = ready_reg;
  assign ms_riscv32_mp_dmdata_out = (final_cycle && !write_reg) ? rd_word : 32'h0;
endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// Directed bench for msrv32_dmem_responder: zero-wait-state instance u0 and three-wait-state instance u3 share stimulus.
// Expectations for the error-response cases follow MSRV32_DMEM_ERRRESP_EN.
module tb_msrv32_dmem_responder;
`ifdef MSRV32_DMEM_ERRRESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic        req;
  logic [1:0]  htrans;
  logic        ready0, resp0, ready3, resp3;
  logic [31:0] rd0, rd3;

  int total = 0;
  int bad   = 0;

  msrv32_dmem_responder u0 (
    .ms_riscv32_mp_clk_in       (clk),
    .ms_riscv32_mp_rst_in       (rst),
    .ms_riscv32_mp_dmaddr_in    (addr),
    .ms_riscv32_mp_dmdata_in    (wdata),
    .ms_riscv32_mp_dmwr_mask_in (mask),
    .ms_riscv32_mp_req_in       (req),
    .ahb_htrans_in              (htrans),
    .ahb_ready_out              (ready0),
    .ahb_resp_out               (resp0),
    .ms_riscv32_mp_dmdata_out   (rd0)
  );

  msrv32_dmem_responder #(.WAIT_STATES(3)) u3 (
    .ms_riscv32_mp_clk_in       (clk),
    .ms_riscv32_mp_rst_in       (rst),
    .ms_riscv32_mp_dmaddr_in    (addr),
    .ms_riscv32_mp_dmdata_in    (wdata),
    .ms_riscv32_mp_dmwr_mask_in (mask),
    .ms_riscv32_mp_req_in       (req),
    .ahb_htrans_in              (htrans),
    .ahb_ready_out              (ready3),
    .ahb_resp_out               (resp3),
    .ms_riscv32_mp_dmdata_out   (rd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [1:0]  htrans;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        ready;
    logic        resp;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one cycle just after the rising edge, check at the falling edge.
  task automatic step(input int which, input logic r, input logic [1:0] ht, input logic [31:0] a,
                      input logic [3:0] m, input logic [31:0] wd, input logic rs,
                      input logic e_ready, input logic e_resp, input logic [31:0] e_rd,
                      input string name);
    logic        a_ready, a_resp;
    logic [31:0] a_rd;
    req = r; htrans = ht; addr = a; mask = m; wdata = wd; rst = rs;
    @(negedge clk);
    a_ready = (which == 3) ? ready3 : ready0;
    a_resp  = (which == 3) ? resp3  : resp0;
    a_rd    = (which == 3) ? rd3    : rd0;
    $display("u%0d %-12s req=%b htrans=%b addr=%h mask=%b wdata=%h -> ready=%b resp=%b rd=%h",
             which, name, r, ht, a, m, wd, a_ready, a_resp, a_rd);
    chk({name, ".ready"}, 32'(a_ready), 32'(e_ready));
    chk({name, ".resp"},  32'(a_resp),  32'(e_resp));
    chk({name, ".rd"},    a_rd,         e_rd);
    @(posedge clk); #1;
  endtask

  task automatic tick(input logic rs);
    req = 1'b0; htrans = 2'b00; addr = 32'h0; mask = 4'h0; wdata = 32'h0; rst = rs;
    @(posedge clk); #1;
  endtask

  initial begin
    // Zero-wait pipelined vectors; wdata belongs to the transfer in its data phase.
    vecs[0]  = '{1'b0, 2'b00, 32'h0,         4'h0, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 2'b10, 32'h8000_0000, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 2'b10, 32'h8000_0000, 4'h0, 32'hAABB_CCDD, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 2'b00, 32'h0,         4'h0, 32'h0,         1'b1, 1'b0, 32'hAABB_CCDD};
    vecs[4]  = '{1'b0, 2'b00, 32'h0,         4'h0, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 2'b10, 32'h8000_0004, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 2'b11, 32'h8000_0004, 4'h1, 32'h1122_3344, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 2'b11, 32'h8000_0007, 4'hC, 32'h0000_00EE, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 2'b10, 32'h8000_0004, 4'h0, 32'h5566_0000, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 2'b10, 32'h8000_0000, 4'h0, 32'h0,         1'b1, 1'b0, 32'h5566_33EE};
    vecs[10] = '{1'b0, 2'b00, 32'h0,         4'h0, 32'h0,         1'b1, 1'b0, 32'hAABB_CCDD};
    vecs[11] = '{1'b1, 2'b01, 32'h8000_0000, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 2'b00, 32'h8000_0004, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 2'b10, 32'h8000_0000, 4'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 2'b11, 32'h8000_0004, 4'h0, 32'h0,         1'b1, 1'b0, 32'hAABB_CCDD};
    vecs[15] = '{1'b0, 2'b00, 32'h0,         4'h0, 32'h0,         1'b1, 1'b0, 32'h5566_33EE};
    vecs[16] = '{1'b0, 2'b10, 32'h8000_0000, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0};

    tick(1'b0);
    tick(1'b0);
    rst = 1'b1;
    @(negedge clk);
    $display("reset u0 ready=%b resp=%b rd=%h u3 ready=%b resp=%b rd=%h", ready0, resp0, rd0, ready3, resp3, rd3);
    chk("rst.u0.ready", 32'(ready0), 32'h1);
    chk("rst.u0.resp",  32'(resp0),  32'h0);
    chk("rst.u0.rd",    rd0,         32'h0);
    chk("rst.u3.ready", 32'(ready3), 32'h1);
    chk("rst.u3.resp",  32'(resp3),  32'h0);
    chk("rst.u3.rd",    rd3,         32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      step(0, vecs[i].req, vecs[i].htrans, vecs[i].addr, vecs[i].mask, vecs[i].wdata, 1'b1,
           vecs[i].ready, vecs[i].resp, vecs[i].rd, $sformatf("vec%0d", i));
    end

    // Out-of-range write, then a read issued in the cycle after its data/error phase.
    step(0, 1, 2'b10, 32'h8000_1000, 4'hF, 32'h0,         1, 1,       0,      32'h0, "oor_addr");
    step(0, 0, 2'b00, 32'h0,         4'h0, 32'h1234_5678, 1, !ERR_EN, ERR_EN, 32'h0, "oor_dp1");
    step(0, 1, 2'b10, 32'h8000_0000, 4'h0, 32'h0,         1, 1,       ERR_EN, 32'h0, "oor_dp2");
    step(0, 0, 2'b00, 32'h0,         4'h0, 32'h0,         1, 1,       0,
         ERR_EN ? 32'hAABB_CCDD : 32'h1234_5678, "oor_rd");
    // Mask 0101 is not a legal byte/half/word pattern.
    step(0, 1, 2'b10, 32'h8000_0000, 4'h5, 32'h0,         1, 1,       0,      32'h0, "msk_addr");
    step(0, 0, 2'b00, 32'h0,         4'h0, 32'hFFFF_FFFF, 1, !ERR_EN, ERR_EN, 32'h0, "msk_dp1");
    step(0, 1, 2'b10, 32'h8000_0000, 4'h0, 32'h0,         1, 1,       ERR_EN, 32'h0, "msk_dp2");
    step(0, 0, 2'b00, 32'h0,         4'h0, 32'h0,         1, 1,       0,
         ERR_EN ? 32'hAABB_CCDD : 32'h12FF_56FF, "msk_rd");

    // Three-wait-state instance: clear word 2, write word 3.
    tick(1'b0);
    tick(1'b0);
    step(3, 1, 2'b10, 32'h8000_0008, 4'hF, 32'h0, 1, 1, 0, 32'h0, "w8_addr");
    for (int i = 0; i < 3; i++) step(3, 0, 2'b00, 32'h0, 4'h0, 32'h0, 1, 0, 0, 32'h0, $sformatf("w8_wait%0d", i));
    step(3, 0, 2'b00, 32'h0, 4'h0, 32'h0, 1, 1, 0, 32'h0, "w8_final");
    step(3, 1, 2'b10, 32'h8000_000C, 4'hF, 32'h0, 1, 1, 0, 32'h0, "wc_addr");
    for (int i = 0; i < 3; i++) step(3, 0, 2'b00, 32'h0, 4'h0, 32'h0BAD_CAFE, 1, 0, 0, 32'h0, $sformatf("wc_wait%0d", i));
    step(3, 0, 2'b00, 32'h0, 4'h0, 32'h0BAD_CAFE, 1, 1, 0, 32'h0, "wc_final");

    // Read with a second request held through the wait states.
    step(3, 1, 2'b10, 32'h8000_000C, 4'h0, 32'h0, 1, 1, 0, 32'h0, "rc_addr");
    for (int i = 0; i < 3; i++) step(3, 1, 2'b10, 32'h8000_0008, 4'h0, 32'h0, 1, 0, 0, 32'h0, $sformatf("rc_wait%0d", i));
    step(3, 1, 2'b10, 32'h8000_0008, 4'h0, 32'h0, 1, 1, 0, 32'h0BAD_CAFE, "rc_final");
    for (int i = 0; i < 3; i++) step(3, 0, 2'b00, 32'h0, 4'h0, 32'h0, 1, 0, 0, 32'h0, $sformatf("r8_wait%0d", i));
    step(3, 0, 2'b00, 32'h0, 4'h0, 32'h0, 1, 1, 0, 32'h0, "r8_final");

    // Reset during the second wait cycle of a write aborts it.
    step(3, 1, 2'b10, 32'h8000_0008, 4'hF, 32'h0,         1, 1, 0, 32'h0, "ab_addr");
    step(3, 0, 2'b00, 32'h0,         4'h0, 32'hCAFE_F00D, 1, 0, 0, 32'h0, "ab_wait0");
    step(3, 0, 2'b00, 32'h0,         4'h0, 32'hCAFE_F00D, 0, 0, 0, 32'h0, "ab_wait1");
    step(3, 0, 2'b00, 32'h0,         4'h0, 32'hCAFE_F00D, 1, 1, 0, 32'h0, "ab_after");
    step(3, 1, 2'b10, 32'h8000_0008, 4'h0, 32'h0,         1, 1, 0, 32'h0, "ab_rd_addr");
    for (int i = 0; i < 3; i++) step(3, 0, 2'b00, 32'h0, 4'h0, 32'hCAFE_F00D, 1, 0, 0, 32'h0, $sformatf("ab_rd_wait%0d", i));
    step(3, 0, 2'b00, 32'h0, 4'h0, 32'hCAFE_F00D, 1, 1, 0, 32'h0, "ab_rd_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/msrv32_dmem_responder.md
Name: msrv32_dmem_responder

Overview:
- Data-memory slave at the far end of the msrv32 store/load data bus; responds to requests issued by msrv32_store_unit (and the load path).
- Accepts AHB-lite-style transfers: address phase, then data phase.
- Performs byte-masked writes or word reads on an internal word-addressed RAM.
- Inserts a programmable number of wait states and drives ahb_ready back to the requester.

Parameters:
- DEPTH, 1024, number of 32-bit words in the RAM (power of two).
- BASE_ADDR, 32'h8000_0000, byte address mapped to word 0.
- WAIT_STATES, 0, ready-low cycles inserted in each OKAY data phase (0..15).

Ports:
- ms_riscv32_mp_clk_in  input  1  clock; all logic on the rising edge.
- ms_riscv32_mp_rst_in  input  1  synchronous, active-low reset.
- ms_riscv32_mp_dmaddr_in  input  32  byte address; sampled in the address phase.
- ms_riscv32_mp_dmdata_in  input  32  write data; sampled in the final data-phase cycle.
- ms_riscv32_mp_dmwr_mask_in  input  4  byte-lane write mask; 4'b0000 means read.
- ms_riscv32_mp_req_in  input  1  request valid.
- ahb_htrans_in  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- ahb_ready_out  output  1  transfer-complete/ready (HREADY).
- ahb_resp_out  output  1  0 = OKAY, 1 = ERROR.
- ms_riscv32_mp_dmdata_out  output  32  read data.

Behaviour:
- Reset (rst_in = 0 at a clock edge):
  - state returns to IDLE; ahb_ready_out = 1; ahb_resp_out = 0; dmdata_out = 0.
  - Latched address/mask and the wait counter are cleared.
  - RAM contents are not cleared.
  - A reset asserted mid-data-phase aborts the transfer; the pending write is never committed.
- Address-phase accept: on a clock edge where ahb_ready_out = 1, req_in = 1 and htrans_in[1] = 1 (NONSEQ or SEQ):
  - latch addr, mask and is_write (mask != 0);
  - compute word index = (addr - BASE_ADDR) >> 2; addr[1:0] is ignored.
- IDLE or BUSY htrans, or req_in = 0, during a ready cycle: no transfer; stay in IDLE.
- States: IDLE, DATA, ERR1, ERR2.
- IDLE → DATA on accept with an in-range address. The wait counter loads WAIT_STATES.
- DATA:
  - While counter > 0: ready = 0, resp = 0, and the counter decrements each cycle.
  - At counter = 0 (final cycle): ready = 1, resp = 0.
  - Write: for each mask bit i set, byte i of RAM[index] takes dmdata_in[8i+7:8i] at the closing edge.
  - Read: dmdata_out = RAM[index] combinationally during the final cycle.
- Back-to-back: a new accept in DATA's final cycle → DATA again (counter reloads). Otherwise → IDLE.
- Read-after-write to the same word in consecutive transfers returns the newly written bytes.
- dmdata_out = 0 in every cycle other than the final cycle of a read data phase.
- Latency: OKAY data phase = WAIT_STATES + 1 cycles after the address phase. With WAIT_STATES = 0, one transfer completes per cycle.
- ERR1 / ERR2: two-cycle AHB error response.
  - ERR1: ready = 0, resp = 1.
  - ERR2: ready = 1, resp = 1. An accept in ERR2 is legal and proceeds like an accept from IDLE.
  - No RAM write and no wait states during an error response.
- Simultaneous events: reset has priority over any accept or commit.

Optional Feature:
- Macro: MSRV32_DMEM_ERRRESP_EN.
- Defined:
  - Out-of-range accept (addr < BASE_ADDR, or addr - BASE_ADDR >= DEPTH*4) → ERR1, then ERR2.
  - Also: a write whose mask is not one of 0001/0010/0100/1000/0011/1100/1111 → ERR1, then ERR2.
- Not defined:
  - ERR states do not exist; ahb_resp_out is tied to 0.
  - Word index wraps modulo DEPTH; every mask pattern is accepted.

Test Plan:
- WAIT_STATES = 0, write 0x80000000 data 0xAABBCCDD mask 1111, then read 0x80000000 → ready stays 1; read data phase returns 0xAABBCCDD one cycle after that read's address phase.
- Partial-lane writes: write mask 0001 data 0x000000EE to 0x80000004 (word preloaded 0x11223344), then mask 1100 data 0x55660000 → read returns 0x556633EE.
- WAIT_STATES = 3, single read → ready low for exactly 3 cycles then high for 1. Second request held during the wait is not accepted until ready = 1.
- Assert reset during the 2nd wait cycle of a write to 0x80000008 (old value 0x0) → ready = 1, resp = 0 on the next cycle; a later read returns 0x00000000.
- ERRRESP_EN defined, write to 0x80001000 with DEPTH = 1024 → cycle 1: ready 0 / resp 1; cycle 2: ready 1 / resp 1; RAM word 0 unchanged. Without the macro, the same write lands in word 0.
- htrans = 01 or 00 with req = 1 → no RAM change, ready stays 1, dmdata_out = 0.
